// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: synchroniser, tick-gated filter, edge pulses,
// long-press detection and optional auto-repeat per channel.
module debounce_multi #(
    parameter int CH_N     = 4,
    parameter int CNT_N    = 7,
    parameter int TICK_DIV = 1,
    parameter int HOLD_N   = 20,
    parameter int REPEAT_N = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [CH_N-1:0] i_in,
    input  logic            i_repeat_en,
    output logic [CH_N-1:0] o_debounced,
    output logic [CH_N-1:0] o_pos,
    output logic [CH_N-1:0] o_neg,
    output logic [CH_N-1:0] o_hold,
    output logic [CH_N-1:0] o_repeat
);

    localparam int CNT_W  = $clog2(CNT_N + 1);
    localparam int HOLD_W = $clog2(HOLD_N + 1);
    localparam int REP_W  = $clog2(REPEAT_N + 1);

    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(CNT_N);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_N);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_N - 1);

    logic [CH_N-1:0] sync0;
    logic [CH_N-1:0] sync1;
    logic            tick;

    logic [CNT_W-1:0]  cnt      [CH_N];
    logic [CNT_W-1:0]  cnt_next [CH_N];
    logic [HOLD_W-1:0] hold_cnt [CH_N];
    logic [HOLD_W-1:0] hold_next[CH_N];
    logic [REP_W-1:0]  rep_cnt  [CH_N];
    logic [REP_W-1:0]  rep_next [CH_N];
    logic [CH_N-1:0]   fired;
    logic [CH_N-1:0]   fired_next;
    logic [CH_N-1:0]   deb_next;
    logic [CH_N-1:0]   hold_pulse;
    logic [CH_N-1:0]   rep_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= i_in;
            sync1 <= sync0;
        end
    end

    generate
        if (TICK_DIV == 1) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_tick_div
            localparam int DIV_W = $clog2(TICK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
            logic [DIV_W-1:0] div;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    div <= '0;
                end else if (div == DIV_LAST) begin
                    div <= '0;
                end else begin
                    div <= div + DIV_W'(1);
                end
            end

            assign tick = (div == DIV_LAST);
        end
    endgenerate

    // The filter counts down while the synchronised level disagrees; reaching zero accepts it.
    always_comb begin
        for (int c = 0; c < CH_N; c++) begin
            deb_next[c] = o_debounced[c];
            cnt_next[c] = cnt[c];
            if (tick) begin
                if (sync1[c] == o_debounced[c]) begin
                    cnt_next[c] = CNT_INIT;
                end else if (cnt[c] != '0) begin
                    cnt_next[c] = cnt[c] - CNT_W'(1);
                end else begin
                    deb_next[c] = sync1[c];
                    cnt_next[c] = CNT_INIT;
                end
            end
        end
    end

    // Counting only runs while the channel was already pressed and stays pressed, so the
    // o_pos cycle starts from zero and a release never emits a stray hold/repeat pulse.
    always_comb begin
        for (int c = 0; c < CH_N; c++) begin
            hold_next[c]  = hold_cnt[c];
            rep_next[c]   = rep_cnt[c];
            fired_next[c] = fired[c];
            hold_pulse[c] = 1'b0;
            rep_pulse[c]  = 1'b0;
            if (!deb_next[c] || !o_debounced[c]) begin
                hold_next[c]  = '0;
                rep_next[c]   = '0;
                fired_next[c] = 1'b0;
            end else if (tick) begin
                if (!fired[c]) begin
                    if (hold_cnt[c] == HOLD_LAST) begin
                        hold_next[c]  = HOLD_MAX;
                        fired_next[c] = 1'b1;
                        hold_pulse[c] = 1'b1;
                    end else begin
                        hold_next[c] = hold_cnt[c] + HOLD_W'(1);
                    end
                end else if (i_repeat_en) begin
                    if (rep_cnt[c] == REP_LAST) begin
                        rep_next[c]  = '0;
                        rep_pulse[c] = 1'b1;
                    end else begin
                        rep_next[c] = rep_cnt[c] + REP_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_debounced <= '0;
            o_pos       <= '0;
            o_neg       <= '0;
            o_hold      <= '0;
            o_repeat    <= '0;
            fired       <= '0;
            for (int c = 0; c < CH_N; c++) begin
                cnt[c]      <= CNT_INIT;
                hold_cnt[c] <= '0;
                rep_cnt[c]  <= '0;
            end
        end else begin
            o_debounced <= deb_next;
            o_pos       <= deb_next & ~o_debounced;
            o_neg       <= ~deb_next & o_debounced;
            o_hold      <= hold_pulse;
            o_repeat    <= rep_pulse;
            fired       <= fired_next;
            for (int c = 0; c < CH_N; c++) begin
                cnt[c]      <= cnt_next[c];
                hold_cnt[c] <= hold_next[c];
                rep_cnt[c]  <= rep_next[c];
            end
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two parameter sets driven by the same random inputs and
// compared every cycle against a run-length based reference model.
module tb_debounce_multi;

    localparam int CH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [CH-1:0] in_vec;
    logic          en;

    logic [CH-1:0] a_deb, a_pos, a_neg, a_hold, a_rep;
    logic [CH-1:0] b_deb, b_pos, b_neg, b_hold, b_rep;

    debounce_multi #(.CH_N(CH), .CNT_N(7), .TICK_DIV(1), .HOLD_N(20), .REPEAT_N(5)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(in_vec), .i_repeat_en(en),
        .o_debounced(a_deb), .o_pos(a_pos), .o_neg(a_neg), .o_hold(a_hold), .o_repeat(a_rep)
    );

    debounce_multi #(.CH_N(CH), .CNT_N(3), .TICK_DIV(4), .HOLD_N(4), .REPEAT_N(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(in_vec), .i_repeat_en(en),
        .o_debounced(b_deb), .o_pos(b_pos), .o_neg(b_neg), .o_hold(b_hold), .o_repeat(b_rep)
    );

    int assertCount;
    int failCount;

    int td[2];
    int cn[2];
    int hn[2];
    int rn[2];

    logic [CH-1:0] d1, d2;
    int            edges;
    int            mdeb [2][CH];
    int            run  [2][CH];
    int            tcnt [2][CH];
    int            rcnt [2][CH];
    logic [CH-1:0] e_deb[2], e_pos[2], e_neg[2], e_hold[2], e_rep[2];

    logic [CH-1:0] lvl;
    int            left[CH];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        d1    = '0;
        d2    = '0;
        edges = 0;
        for (int k = 0; k < 2; k++) begin
            e_deb[k]  = '0;
            e_pos[k]  = '0;
            e_neg[k]  = '0;
            e_hold[k] = '0;
            e_rep[k]  = '0;
            for (int c = 0; c < CH; c++) begin
                mdeb[k][c] = 0;
                run[k][c]  = 0;
                tcnt[k][c] = 0;
                rcnt[k][c] = 0;
            end
        end
    endtask

    // Stable level flips after cn+1 consecutive disagreeing ticks; hold fires when the number
    // of pressed ticks reaches hn; repeats fire on every rn-th enabled tick after that.
    task automatic modelStep();
        if (!rst_n) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit tick;
            tick      = ((edges % td[k]) == td[k] - 1);
            e_pos[k]  = '0;
            e_neg[k]  = '0;
            e_hold[k] = '0;
            e_rep[k]  = '0;
            for (int c = 0; c < CH; c++) begin
                int old_l;
                int new_l;
                int s;
                old_l = mdeb[k][c];
                new_l = old_l;
                s     = int'(d2[c]);
                if (tick) begin
                    if (s == old_l) begin
                        run[k][c] = 0;
                    end else begin
                        run[k][c]++;
                        if (run[k][c] == cn[k] + 1) begin
                            new_l     = s;
                            run[k][c] = 0;
                        end
                    end
                end
                if (new_l == 1 && old_l == 0) e_pos[k][c] = 1'b1;
                if (new_l == 0 && old_l == 1) e_neg[k][c] = 1'b1;
                if (new_l == 0 || old_l == 0) begin
                    tcnt[k][c] = 0;
                    rcnt[k][c] = 0;
                end else if (tick) begin
                    if (tcnt[k][c] < hn[k]) begin
                        tcnt[k][c]++;
                        if (tcnt[k][c] == hn[k]) e_hold[k][c] = 1'b1;
                    end else if (en) begin
                        rcnt[k][c]++;
                        if (rcnt[k][c] % rn[k] == 0) e_rep[k][c] = 1'b1;
                    end
                end
                mdeb[k][c]  = new_l;
                e_deb[k][c] = (new_l != 0);
            end
        end
        edges++;
        d2 = d1;
        d1 = in_vec;
    endtask

    task automatic compareAll();
        checkOutput("a_debounced", 32'(a_deb),  32'(e_deb[0]));
        checkOutput("a_pos",       32'(a_pos),  32'(e_pos[0]));
        checkOutput("a_neg",       32'(a_neg),  32'(e_neg[0]));
        checkOutput("a_hold",      32'(a_hold), 32'(e_hold[0]));
        checkOutput("a_repeat",    32'(a_rep),  32'(e_rep[0]));
        checkOutput("b_debounced", 32'(b_deb),  32'(e_deb[1]));
        checkOutput("b_pos",       32'(b_pos),  32'(e_pos[1]));
        checkOutput("b_neg",       32'(b_neg),  32'(e_neg[1]));
        checkOutput("b_hold",      32'(b_hold), 32'(e_hold[1]));
        checkOutput("b_repeat",    32'(b_rep),  32'(e_rep[1]));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        modelReset();
        #1;
        compareAll();
        repeat (cycles) stepCycle();
        rst_n = 1'b1;
    endtask

    // Counts edges from the one that first samples the new level until a_pos[ch] is seen.
    task automatic measurePos(input int ch, output int n);
        n = -1;
        for (int i = 0; i < 30 && n < 0; i++) begin
            stepCycle();
            if (a_pos[ch]) n = i;
        end
    endtask

    task automatic applyStimulus();
        for (int c = 0; c < CH; c++) begin
            if (left[c] == 0) begin
                lvl[c]  = ~lvl[c];
                left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                      : int'($urandom_range(10, 90));
            end
            left[c]--;
        end
        in_vec = lvl;
        if ($urandom_range(0, 59) == 0) en = ~en;
        if ($urandom_range(0, 1499) == 0) doReset(int'($urandom_range(1, 3)));
    endtask

    initial begin
        int n;
        int holds;
        int reps;
        bit seen;

        assertCount = 0;
        failCount   = 0;
        td = '{1, 4};
        cn = '{7, 3};
        hn = '{20, 4};
        rn = '{5, 2};
        in_vec = '0;
        en     = 1'b1;

        doReset(2);

        in_vec = 4'b0001;
        measurePos(0, n);
        checkOutput("pos_latency", 32'(n), 32'd9);
        stepCycle();
        checkOutput("pos_width", 32'(a_pos[0]), 32'd0);

        holds = 0;
        reps  = 0;
        for (int i = 0; i < 30; i++) begin
            stepCycle();
            if (a_hold[0]) holds++;
            if (a_rep[0])  reps++;
        end
        checkOutput("hold_count", 32'(holds), 32'd1);
        checkOutput("repeat_count", 32'(reps), 32'd2);

        doReset(2);
        measurePos(0, n);
        checkOutput("pos_after_reset", 32'(n), 32'd9);

        in_vec = 4'b0010;
        repeat (15) stepCycle();
        in_vec = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            stepCycle();
            if (a_pos[0] || a_neg[1]) begin
                seen = 1'b1;
                checkOutput("simultaneous", 32'({a_pos[0], a_neg[1]}), 32'd3);
            end
        end
        checkOutput("simultaneous_seen", 32'(seen), 32'd1);

        lvl = in_vec;
        for (int c = 0; c < CH; c++) left[c] = int'($urandom_range(1, 40));
        for (int i = 0; i < 6000; i++) begin
            applyStimulus();
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
